// File: rtl/elastic_fifo_pkg.sv
// Shared arithmetic helpers and the elaboration-time parameter check for elastic_fifo.
package elastic_fifo_pkg;

  // Ceiling log2. Never returns less than 1, so a pointer is always at least one bit wide.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

`ifndef ELASTIC_FIFO_CHECK_PARAMS
`define ELASTIC_FIFO_CHECK_PARAMS(n) \
  if ((n) < 2) begin : g_bad_num_slots \
    $error("elastic_fifo: NUM_SLOTS must be >= 2"); \
  end
`endif

// File: rtl/elastic_fifo_mem.sv
// Token storage: synchronous write port, asynchronous read port, no reset.
module elastic_fifo_mem
  import elastic_fifo_pkg::*;
#(
  parameter int unsigned DATA_TYPE = 32,
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [clog2(NUM_SLOTS)-1:0]     waddr,
  input  logic [DATA_TYPE-1:0]            wdata,
  input  logic [clog2(NUM_SLOTS)-1:0]     raddr,
  output logic [DATA_TYPE-1:0]            rdata
);

  logic [DATA_TYPE-1:0] mem [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_fifo.sv
// Non-transparent valid/ready FIFO that absorbs adder result bursts under consumer stalls.
module elastic_fifo
  import elastic_fifo_pkg::*;
#(
  parameter int unsigned DATA_TYPE = 32,
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready
);

  localparam int unsigned PTR_W = clog2(NUM_SLOTS);
  localparam int unsigned CNT_W = clog2(NUM_SLOTS + 1);

  `ELASTIC_FIFO_CHECK_PARAMS(NUM_SLOTS)

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic                 push;
  logic                 pop;
  logic [DATA_TYPE-1:0] rdata;

  // Handshake flags come from registered count only; no outs_ready -> ins_ready path.
  assign ins_ready  = (count != CNT_W'(NUM_SLOTS));
  assign outs_valid = (count != CNT_W'(0));
  assign push       = ins_valid & ins_ready;
  assign pop        = outs_valid & outs_ready;
  assign outs       = outs_valid ? rdata : '0;

  // Depth need not be a power of two, so wrap by explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  elastic_fifo_mem #(
    .DATA_TYPE (DATA_TYPE),
    .NUM_SLOTS (NUM_SLOTS)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~rst),
    .waddr (tail),
    .wdata (ins),
    .raddr (head),
    .rdata (rdata)
  );

endmodule
